i_cache_sa: RTL and testbench

I_CACHE_SA -- requirements
Module: i_cache_sa

---
 rtl/i_cache_sa.sv | 218 +++++++++++++++++++++
 tb/tb_i_cache_sa.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_sa.sv
// i_cache_sa: set-associative instruction cache with tree-PLRU replacement.
// A fetch that hits returns its word on the cycle after acceptance. A fetch
// that misses requests the whole line from memory, fills it into the victim
// way and then returns the requested word.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   core_req_valid/addr      fetch request (word-aligned PC)
//   core_req_ready           request accepted this cycle
//   core_rsp_valid/instr     fetched instruction, one-cycle pulse
//   mem_req_valid/addr       line-fill request (line-aligned), held until ready
//   mem_req_ready            memory accepts the fill request
//   mem_rsp_valid/data       fill line, word k at bits [32k+31:32k]
//   flush                    invalidate-all pulse
//   miss_cnt                 saturating count of accepted misses
//
// state    | meaning
// IDLE     | accepting fetches, serving hits, applying flushes
// MISS_REQ | presenting the line-fill request to memory
// WAIT_RSP | waiting for the fill line
module i_cache_sa #(
    parameter int WAYS     = 4,
    parameter int SETS     = 16,
    parameter int CL_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_valid,
    input  logic [31:0]             core_req_addr,
    output logic                    core_req_ready,
    output logic                    core_rsp_valid,
    output logic [31:0]             core_rsp_instr,
    output logic                    mem_req_valid,
    output logic [31:0]             mem_req_addr,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [32*CL_WORDS-1:0]  mem_rsp_data,
    input  logic                    flush,
    output logic [31:0]             miss_cnt
);
    localparam int OFF_W  = $clog2(CL_WORDS);
    localparam int IDX_B  = $clog2(SETS);
    localparam int IDX_W  = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_W  = 30 - OFF_W - IDX_B;
    localparam int LINE_W = 32 * CL_WORDS;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int NODES  = WAYS - 1;

    if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("i_cache_sa: WAYS must be a power of 2 and >= 2");
    end
    if (SETS < 1 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("i_cache_sa: SETS must be a power of 2 and >= 1");
    end
    if (CL_WORDS < 2 || (CL_WORDS & (CL_WORDS - 1)) != 0) begin : g_bad_words
        $error("i_cache_sa: CL_WORDS must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {IDLE, MISS_REQ, WAIT_RSP} state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return IDX_W'((a >> (OFF_W + 2)) & 32'(SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return TAG_W'(a >> (OFF_W + 2 + IDX_B));
    endfunction

    function automatic logic [OFF_W-1:0] off_of(input logic [31:0] a);
        return OFF_W'((a >> 2) & 32'(CL_WORDS - 1));
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] t);
        int              node;
        logic            d;
        logic [WAY_W-1:0] w;
        node = 0;
        w    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            d    = t[node];
            w    = WAY_W'({w, d});
            node = 2 * node + 1 + int'(d);
        end
        return w;
    endfunction

    // Point every node on the accessed way's path at the other subtree.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                    input logic [WAY_W-1:0] w);
        int   node;
        logic b;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b       = w[WAY_W-1-l];
            t[node] = ~b;
            node    = 2 * node + 1 + int'(b);
        end
        return t;
    endfunction

    state_t             state;
    logic [WAYS-1:0]    valid    [SETS];
    logic [NODES-1:0]   plru     [SETS];
    logic [TAG_W-1:0]   tag_arr  [SETS][WAYS];
    logic [LINE_W-1:0]  data_arr [SETS][WAYS];
    logic [31:0]        req_addr_q;
    logic               flush_pend;

    logic [IDX_W-1:0]   req_idx, cap_idx;
    logic [TAG_W-1:0]   req_tag, cap_tag;
    logic [OFF_W-1:0]   req_off, cap_off;
    logic               hit;
    logic [WAY_W-1:0]   hit_way, victim;
    logic [31:0]        hit_word, fill_word;
    logic               flush_apply;

    assign req_idx = idx_of(core_req_addr);
    assign req_tag = tag_of(core_req_addr);
    assign req_off = off_of(core_req_addr);
    assign cap_idx = idx_of(req_addr_q);
    assign cap_tag = tag_of(req_addr_q);
    assign cap_off = off_of(req_addr_q);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; the PLRU choice applies only to a full set.
    always_comb begin
        victim = plru_victim(plru[cap_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[cap_idx][w]) victim = WAY_W'(w);
        end
    end

    assign hit_word  = data_arr[req_idx][hit_way][32*req_off +: 32];
    assign fill_word = mem_rsp_data[32*cap_off +: 32];

    // A pending flush takes over the first IDLE cycle, just like a live one.
    assign flush_apply    = (state == IDLE) && (flush || flush_pend);
    assign core_req_ready = (state == IDLE) && !flush_apply;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            flush_pend     <= 1'b0;
            miss_cnt       <= '0;
            core_rsp_valid <= 1'b0;
            core_rsp_instr <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            req_addr_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            core_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_apply) begin
                        flush_pend <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            plru[s]  <= '0;
                        end
                    end else if (core_req_valid) begin
                        if (hit) begin
                            core_rsp_valid <= 1'b1;
                            core_rsp_instr <= hit_word;
                            plru[req_idx]  <= plru_touch(plru[req_idx], hit_way);
                        end else begin
                            req_addr_q    <= core_req_addr;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= core_req_addr & ~32'(4 * CL_WORDS - 1);
                            state         <= MISS_REQ;
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_rsp_valid) begin
                        valid[cap_idx][victim] <= 1'b1;
                        plru[cap_idx]          <= plru_touch(plru[cap_idx], victim);
                        core_rsp_valid         <= 1'b1;
                        core_rsp_instr         <= fill_word;
                        state                  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == WAIT_RSP && mem_rsp_valid) begin
            tag_arr[cap_idx][victim]  <= cap_tag;
            data_arr[cap_idx][victim] <= mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_i_cache_sa.sv
// Directed testbench for i_cache_sa (WAYS=4, SETS=16, CL_WORDS=4).
// Memory returns word 0xA000_0000 | byte_address for every location.
module tb_i_cache_sa;
    logic         clk = 1'b0;
    logic         rst;
    logic         core_req_valid;
    logic [31:0]  core_req_addr;
    logic         core_req_ready;
    logic         core_rsp_valid;
    logic [31:0]  core_rsp_instr;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic         flush;
    logic [31:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    i_cache_sa #(.WAYS(4), .SETS(16), .CL_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
        .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
        .core_rsp_instr(core_rsp_instr), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .flush(flush), .miss_cnt(miss_cnt)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] la);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[32*k +: 32] = word_of(la + 32'(4 * k));
        return d;
    endfunction

    // Drives one fetch to completion, serving a miss immediately.
    task automatic fetch(input logic [31:0] a, output logic hit, output logic [31:0] instr,
                         output logic [31:0] maddr, output logic ok);
        int n;
        ok = 1'b1; hit = 1'b0; instr = '0; maddr = '0;
        @(negedge clk);
        core_req_valid = 1'b1;
        core_req_addr  = a;
        #1;
        n = 0;
        while (!core_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!core_req_ready) ok = 1'b0;
        @(negedge clk);
        core_req_valid = 1'b0;
        if (core_rsp_valid) begin
            hit   = 1'b1;
            instr = core_rsp_instr;
        end else if (mem_req_valid) begin
            maddr         = mem_req_addr;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line_of(maddr);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (core_rsp_valid) instr = core_rsp_instr;
            else ok = 1'b0;
        end else begin
            ok = 1'b0;
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        #1;
        while (!core_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = core_req_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (core_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valids rsp=%b mreq=%b expected 0 0", core_rsp_valid, mem_req_valid);
        end
        checks++;
        if (mem_req_addr !== 32'h0 || core_rsp_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data maddr=%h instr=%h expected 0", mem_req_addr, core_rsp_instr);
        end
        checks++;
        if (miss_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_miss_cnt got=%0d expected 0", miss_cnt);
        end
        checks++;
        if (core_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b expected 1", core_req_ready);
        end
    endtask

    task automatic test_cold_miss();
        logic h, ok; logic [31:0] ins, ma;
        fetch(32'h104, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0) begin
            failures++;
            $display("FAIL cold_miss ok=%b hit=%b expected ok=1 hit=0", ok, h);
        end
        checks++;
        if (ma !== 32'h100) begin
            failures++;
            $display("FAIL cold_fill_addr got=%h expected 00000100", ma);
        end
        checks++;
        if (ins !== 32'hA000_0104) begin
            failures++;
            $display("FAIL cold_instr got=%h expected a0000104", ins);
        end
        checks++;
        if (miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL cold_miss_cnt got=%0d expected %0d", miss_cnt, exp_miss);
        end
        @(negedge clk);
        checks++;
        if (core_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rsp_pulse got=%b expected 0", core_rsp_valid);
        end
    endtask

    task automatic test_hit();
        logic h, ok; logic [31:0] ins, ma;
        fetch(32'h108, h, ins, ma, ok);
        checks++;
        if (ok !== 1'b1 || h !== 1'b1 || ins !== 32'hA000_0108) begin
            failures++;
            $display("FAIL hit_108 ok=%b hit=%b instr=%h expected 1 1 a0000108", ok, h, ins);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL hit_side mreq=%b miss_cnt=%0d expected 0 %0d", mem_req_valid, miss_cnt, exp_miss);
        end
    endtask

    task automatic test_plru();
        logic h, ok; logic [31:0] ins, ma;
        logic [31:0] fills [4] = '{32'h000, 32'h100, 32'h200, 32'h300};
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        foreach (fills[i]) begin
            fetch(fills[i], h, ins, ma, ok);
            exp_miss++;
            checks++;
            if (ok !== 1'b1 || h !== 1'b0 || ma !== fills[i] || ins !== word_of(fills[i])) begin
                failures++;
                $display("FAIL plru_fill_%0d ok=%b hit=%b maddr=%h instr=%h expected 1 0 %h %h",
                         i, ok, h, ma, ins, fills[i], word_of(fills[i]));
            end
        end
        fetch(32'h000, h, ins, ma, ok);
        checks++;
        if (ok !== 1'b1 || h !== 1'b1 || ins !== 32'hA000_0000) begin
            failures++;
            $display("FAIL plru_hit_000 ok=%b hit=%b instr=%h expected 1 1 a0000000", ok, h, ins);
        end
        // Tree after the hit on way 0 points right then left: way 2 (0x200) goes.
        fetch(32'h404, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || ma !== 32'h400 || ins !== 32'hA000_0404) begin
            failures++;
            $display("FAIL plru_miss_400 ok=%b hit=%b maddr=%h instr=%h expected 1 0 400 a0000404", ok, h, ma, ins);
        end
        fetch(32'h10C, h, ins, ma, ok);
        checks++;
        if (ok !== 1'b1 || h !== 1'b1 || ins !== 32'hA000_010C) begin
            failures++;
            $display("FAIL plru_hit_100 ok=%b hit=%b instr=%h expected 1 1 a000010c", ok, h, ins);
        end
        fetch(32'h200, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || ma !== 32'h200) begin
            failures++;
            $display("FAIL plru_evicted_200 ok=%b hit=%b maddr=%h expected 1 0 200", ok, h, ma);
        end
        checks++;
        if (miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL plru_miss_cnt got=%0d expected %0d", miss_cnt, exp_miss);
        end
    endtask

    task automatic test_stall();
        logic ok;
        @(negedge clk);
        core_req_valid = 1'b1;
        core_req_addr  = 32'h504;
        wait_ready(ok);
        @(negedge clk);
        core_req_valid = 1'b0;
        exp_miss++;
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept ready=%b expected 1", ok);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin
                failures++;
                $display("FAIL stall_hold_%0d mreq=%b maddr=%h expected 1 00000500", i, mem_req_valid, mem_req_addr);
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_transfer mreq=%b expected 0", mem_req_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_of(32'h500);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++;
        if (core_rsp_valid !== 1'b1 || core_rsp_instr !== 32'hA000_0504) begin
            failures++;
            $display("FAIL stall_rsp valid=%b instr=%h expected 1 a0000504", core_rsp_valid, core_rsp_instr);
        end
    endtask

    task automatic test_flush();
        logic h, ok; logic [31:0] ins, ma;
        @(negedge clk);
        core_req_valid = 1'b1;
        core_req_addr  = 32'h604;
        wait_ready(ok);
        @(negedge clk);
        core_req_valid = 1'b0;
        exp_miss++;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_of(32'h600);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (ok !== 1'b1 || core_rsp_valid !== 1'b1 || core_rsp_instr !== 32'hA000_0604) begin
            failures++;
            $display("FAIL flush_wait_rsp ok=%b valid=%b instr=%h expected 1 1 a0000604", ok, core_rsp_valid, core_rsp_instr);
        end
        checks++;
        if (core_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_pending_ready got=%b expected 0", core_req_ready);
        end
        fetch(32'h604, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || ma !== 32'h600) begin
            failures++;
            $display("FAIL flush_refetch ok=%b hit=%b maddr=%h expected 1 0 600", ok, h, ma);
        end
        fetch(32'h400, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || ins !== 32'hA000_0400) begin
            failures++;
            $display("FAIL flush_other_line ok=%b hit=%b instr=%h expected 1 0 a0000400", ok, h, ins);
        end
        @(negedge clk);
        flush          = 1'b1;
        core_req_valid = 1'b1;
        core_req_addr  = 32'h604;
        #1;
        checks++;
        if (core_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_ready got=%b expected 0", core_req_ready);
        end
        @(negedge clk);
        flush          = 1'b0;
        core_req_valid = 1'b0;
        checks++;
        if (core_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL flush_idle_reject rsp=%b mreq=%b miss_cnt=%0d expected 0 0 %0d",
                     core_rsp_valid, mem_req_valid, miss_cnt, exp_miss);
        end
        fetch(32'h604, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL flush_idle_effect ok=%b hit=%b miss_cnt=%0d expected 1 0 %0d", ok, h, miss_cnt, exp_miss);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic h, ok; logic [31:0] ins, ma;
        @(negedge clk);
        core_req_valid = 1'b1;
        core_req_addr  = 32'h704;
        wait_ready(ok);
        @(negedge clk);
        core_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        exp_miss = 0;
        #1;
        checks++;
        if (core_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || miss_cnt !== 32'd0) begin
            failures++;
            $display("FAIL async_reset rsp=%b mreq=%b maddr=%h miss_cnt=%0d expected 0 0 0 0",
                     core_rsp_valid, mem_req_valid, mem_req_addr, miss_cnt);
        end
        @(negedge clk);
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_of(32'h700);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++;
        if (core_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_rsp_ignored rsp=%b expected 0", core_rsp_valid);
        end
        fetch(32'h704, h, ins, ma, ok);
        exp_miss++;
        checks++;
        if (ok !== 1'b1 || h !== 1'b0 || ma !== 32'h700 || ins !== 32'hA000_0704 || miss_cnt !== 32'(exp_miss)) begin
            failures++;
            $display("FAIL post_reset_miss ok=%b hit=%b maddr=%h instr=%h miss_cnt=%0d expected 1 0 700 a0000704 %0d",
                     ok, h, ma, ins, miss_cnt, exp_miss);
        end
    endtask

    initial begin
        rst            = 1'b0;
        core_req_valid = 1'b0;
        core_req_addr  = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        flush          = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_plru();
        test_stall();
        test_flush();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
